// File: rtl/iagc_dac_init.sv
// iagc_dac_init: DAC configuration sequencer that shifts NUM_WORDS words out over a
// write-only mode-0 SPI link and then raises o_initDone for the IAGC control FSM.
// Optional feature: define IAGC_DAC_INIT_RETRIGGER_EN to allow i_start in DONE to
// re-send the whole sequence; by default DONE is terminal until reset.
module iagc_dac_init #(
    parameter int WORD_WIDTH = 16,
    parameter int NUM_WORDS  = 4,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic                            i_clock,
    input  logic                            i_nReset,
    input  logic                            i_start,
    input  logic [NUM_WORDS*WORD_WIDTH-1:0] i_configWords,
    output logic                            o_sclk,
    output logic                            o_mosi,
    output logic                            o_csN,
    output logic                            o_busy,
    output logic                            o_initDone
);

    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int BW = $clog2(WORD_WIDTH + 1);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_WIDTH);
    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DW-1:0]         div_q, div_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [WORD_WIDTH-1:0] sh_q, sh_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  csn_q, csn_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [WORD_WIDTH-1:0] cur_word;

    // Select the configuration word addressed by the current word index
    always_comb begin
        cur_word = '0;
        for (int i = 0; i < NUM_WORDS; i++)
            if (idx_q == IW'(i)) cur_word = i_configWords[i*WORD_WIDTH +: WORD_WIDTH];
    end

    // Sequencer next-state: load word, clock out bits, hold CS high between words, finish
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        div_d   = div_q;
        gap_d   = gap_q;
        sh_d    = sh_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        csn_d   = csn_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_LOAD;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                sh_d    = cur_word;
                mosi_d  = cur_word[WORD_WIDTH-1];
                csn_d   = 1'b0;
                sclk_d  = 1'b0;
                div_d   = '0;
                bit_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (div_q != DIV_MAX) begin
                    div_d = div_q + DW'(1);
                end else begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        bit_d = bit_q + BW'(1);
                    end else if (bit_q == LAST_BIT) begin
                        // Final falling edge: close the frame and park MOSI low
                        csn_d  = 1'b1;
                        mosi_d = 1'b0;
                        gap_d  = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = S_GAP;
                        end
                    end else begin
                        sh_d   = {sh_q[WORD_WIDTH-2:0], 1'b0};
                        mosi_d = sh_q[WORD_WIDTH-2];
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_MAX) begin
                    idx_d   = idx_q + IW'(1);
                    state_d = S_LOAD;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_DONE: begin
`ifdef IAGC_DAC_INIT_RETRIGGER_EN
                if (i_start) begin
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
`else
                state_d = S_DONE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge i_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            gap_q   <= '0;
            sh_q    <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            csn_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            sh_q    <= sh_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            csn_q   <= csn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_sclk     = sclk_q;
    assign o_mosi     = mosi_q;
    assign o_csN      = csn_q;
    assign o_busy     = busy_q;
    assign o_initDone = done_q;

endmodule
